// File: rtl/vscale_inst_buffer.sv
// Instruction queue between the imem response path and decode.
// First-word-fall-through head, single-cycle flush, no bypass when full.
module vscale_inst_buffer #(
  parameter int                 XPR_LEN  = 32,
  parameter int                 DEPTH    = 2,
  parameter logic [XPR_LEN-1:0] NOP_INST = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     imem_rsp_valid,
  input  logic [XPR_LEN-1:0]       imem_rsp_inst,
  input  logic [XPR_LEN-1:0]       imem_rsp_pc,
  output logic                     imem_rsp_ready,
  input  logic                     flush,
  output logic                     dec_valid,
  output logic [XPR_LEN-1:0]       dec_inst,
  output logic [XPR_LEN-1:0]       dec_pc,
  output logic                     dec_misaligned,
  input  logic                     dec_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [XPR_LEN-1:0] inst_mem [DEPTH];
  logic [XPR_LEN-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               push;
  logic               pop;

  assign imem_rsp_ready = (count != FULL_COUNT);
  assign dec_valid      = (count != '0);
  assign push           = imem_rsp_valid & imem_rsp_ready & ~flush;
  assign pop            = dec_valid & dec_ready & ~flush;

  assign dec_inst       = dec_valid ? inst_mem[rd_ptr] : NOP_INST;
  assign dec_pc         = dec_valid ? pc_mem[rd_ptr] : '0;
  assign dec_misaligned = dec_valid & (dec_pc[1:0] != 2'b00);

  // Flush wins over any same-cycle push/pop and rewinds both pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_rsp_inst;
      pc_mem[wr_ptr]   <= imem_rsp_pc;
    end
  end

endmodule

// File: tb/tb_vscale_inst_buffer.sv
// Self-checking bench for vscale_inst_buffer: directed cases plus random
// traffic compared against a queue-based model of the buffer.
module tb_vscale_inst_buffer;

  localparam int          XPR_LEN = 32;
  localparam int          DEPTH   = 2;
  localparam logic [31:0] NOP     = 32'h00000013;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_inst;
  logic [31:0]       imem_rsp_pc;
  logic              imem_rsp_ready;
  logic              flush;
  logic              dec_valid;
  logic [31:0]       dec_inst;
  logic [31:0]       dec_pc;
  logic              dec_misaligned;
  logic              dec_ready;
  logic [1:0]        count;

  int checks = 0;
  int errors = 0;

  // Each model entry is {inst, pc}; index 0 is the head.
  logic [63:0] model_q[$];

  vscale_inst_buffer #(.XPR_LEN(XPR_LEN), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_inst  (imem_rsp_inst),
    .imem_rsp_pc    (imem_rsp_pc),
    .imem_rsp_ready (imem_rsp_ready),
    .flush          (flush),
    .dec_valid      (dec_valid),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .dec_misaligned (dec_misaligned),
    .dec_ready      (dec_ready),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    exp_valid = (model_q.size() != 0);
    exp_inst  = exp_valid ? model_q[0][63:32] : NOP;
    exp_pc    = exp_valid ? model_q[0][31:0] : 32'h0;
    checkOutput({tag, ".dec_valid"}, 32'(dec_valid), 32'(exp_valid));
    checkOutput({tag, ".dec_inst"}, dec_inst, exp_inst);
    checkOutput({tag, ".dec_pc"}, dec_pc, exp_pc);
    checkOutput({tag, ".dec_misaligned"}, 32'(dec_misaligned),
                32'(exp_valid && (exp_pc % 4 != 0)));
    checkOutput({tag, ".count"}, 32'(count), 32'(model_q.size()));
    checkOutput({tag, ".ready"}, 32'(imem_rsp_ready), 32'(model_q.size() < DEPTH));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at negedge.
  task automatic applyStimulus(input string tag, input logic v, input logic [31:0] inst,
                               input logic [31:0] pc, input logic fl, input logic rdy);
    bit do_push;
    bit do_pop;
    imem_rsp_valid = v;
    imem_rsp_inst  = inst;
    imem_rsp_pc    = pc;
    flush          = fl;
    dec_ready      = rdy;
    @(posedge clk);
    do_push = v && (model_q.size() < DEPTH) && !fl;
    do_pop  = (model_q.size() != 0) && rdy && !fl;
    if (fl) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({inst, pc});
    end
    @(negedge clk);
    checkAll(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_inst = '0;
    imem_rsp_pc = '0;
    flush = 1'b0;
    dec_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkAll("reset");
    reset_n = 1'b1;
    @(negedge clk);
    checkAll("post_reset");
    checkOutput("nop_before_push", dec_inst, 32'h00000013);

    // Single push visible next cycle.
    applyStimulus("push1", 1, 32'h00500093, 32'h200, 0, 0);
    checkOutput("push1_inst", dec_inst, 32'h00500093);
    applyStimulus("drain1", 0, 0, 0, 0, 1);

    // Fill, reject third word, then drain in order.
    applyStimulus("fill_a", 1, 32'h11111111, 32'h200, 0, 0);
    applyStimulus("fill_b", 1, 32'h22222222, 32'h204, 0, 0);
    checkOutput("full_ready", 32'(imem_rsp_ready), 32'd0);
    applyStimulus("fill_rej", 1, 32'h33333333, 32'h208, 0, 0);
    applyStimulus("drain_a", 0, 0, 0, 0, 1);
    checkOutput("order_second", dec_pc, 32'h204);
    applyStimulus("drain_b", 0, 0, 0, 0, 1);

    // Simultaneous push/pop across pointer wraps.
    applyStimulus("wrap_seed", 1, 32'hA0000000, 32'h2fc, 0, 0);
    for (int i = 0; i < 10; i++)
      applyStimulus("wrap", 1, 32'hA0000001 + 32'(i), 32'h300 + 32'(4 * i), 0, 1);
    checkOutput("wrap_head", dec_pc, 32'h324);
    applyStimulus("wrap_drain", 0, 0, 0, 0, 1);

    // Flush with two entries and a same-cycle push.
    applyStimulus("fl_a", 1, 32'hB0000000, 32'h400, 0, 0);
    applyStimulus("fl_b", 1, 32'hB0000001, 32'h404, 0, 0);
    applyStimulus("flush", 1, 32'hDEADBEEF, 32'h408, 1, 1);
    checkOutput("flush_inst", dec_inst, 32'h00000013);
    applyStimulus("post_flush", 0, 0, 0, 0, 1);
    applyStimulus("flush_empty", 0, 0, 0, 1, 1);

    // Misaligned flag follows the head entry.
    applyStimulus("mis_a", 1, 32'hC0000000, 32'h202, 0, 0);
    checkOutput("mis_set", 32'(dec_misaligned), 32'd1);
    applyStimulus("mis_b", 1, 32'hC0000001, 32'h204, 0, 1);
    checkOutput("mis_clr", 32'(dec_misaligned), 32'd0);
    applyStimulus("mis_drain", 0, 0, 0, 0, 1);

    // Asynchronous reset between clock edges.
    applyStimulus("ar_a", 1, 32'hD0000000, 32'h500, 0, 0);
    applyStimulus("ar_b", 1, 32'hD0000001, 32'h504, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    model_q.delete();
    checkAll("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    checkAll("async_release");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      applyStimulus("rand", ($urandom_range(9) < 7), $urandom, rpc,
                    ($urandom_range(15) == 0), ($urandom_range(1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
